// File: rtl/clock_pkg.sv
// Mode codes shared by the mode sequencer, led_driver and benches,
// plus small helpers for classifying and stepping through those codes.
package clock_pkg;

    localparam logic [3:0] TIME_DISP         = 4'd0;
    localparam logic [3:0] DATE_DISP         = 4'd1;
    localparam logic [3:0] TIME_EDIT_SECOND  = 4'd2;
    localparam logic [3:0] TIME_EDIT_MINUTE  = 4'd3;
    localparam logic [3:0] TIME_EDIT_HOUR    = 4'd4;
    localparam logic [3:0] TIME_EDIT_DAY     = 4'd5;
    localparam logic [3:0] TIME_EDIT_MONTH   = 4'd6;
    localparam logic [3:0] TIME_EDIT_YEAR    = 4'd7;
    localparam logic [3:0] ALARM_DISP        = 4'd8;
    localparam logic [3:0] ALARM_EDIT_SECOND = 4'd9;
    localparam logic [3:0] ALARM_EDIT_MINUTE = 4'd10;
    localparam logic [3:0] ALARM_EDIT_HOUR   = 4'd11;
    localparam logic [3:0] TIMER_DISP        = 4'd12;
    localparam logic [3:0] TIMER_EDIT_SECOND = 4'd13;
    localparam logic [3:0] TIMER_EDIT_MINUTE = 4'd14;
    localparam logic [3:0] TIMER_EDIT_HOUR   = 4'd15;

    function automatic logic is_edit(input logic [3:0] s);
        return !(s == TIME_DISP || s == DATE_DISP || s == ALARM_DISP || s == TIMER_DISP);
    endfunction

    // Display state an edit code falls back to; relies on the group ordering of the codes.
    function automatic logic [3:0] group_disp(input logic [3:0] s);
        if (s >= TIMER_DISP)
            return TIMER_DISP;
        else if (s >= ALARM_DISP)
            return ALARM_DISP;
        return TIME_DISP;
    endfunction

    function automatic logic [3:0] next_field(input logic [3:0] s);
        case (s)
            TIME_EDIT_YEAR:  return TIME_EDIT_SECOND;
            ALARM_EDIT_HOUR: return ALARM_EDIT_SECOND;
            TIMER_EDIT_HOUR: return TIMER_EDIT_SECOND;
            default:         return s + 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/btn_press_detect.sv
// One raw active-low button: 2-FF synchroniser, saturating hold counter and
// short/long press events, plus synced edge strobes for activity tracking.
module btn_press_detect #(
    parameter int LONG_PRESS_CYC = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic short_evt,
    output logic long_evt,
    output logic fall_evt,
    output logic rise_evt
);

    localparam int HW = $clog2(LONG_PRESS_CYC + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYC);

    logic          sync1;
    logic          sync2;
    logic          prev;
    logic [HW-1:0] hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
            hold  <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
            if (sync2)
                hold <= '0;
            else if (hold != HOLD_MAX)
                hold <= hold + 1'b1;
        end
    end

    assign fall_evt  = prev & ~sync2;
    assign rise_evt  = ~prev & sync2;
    // hold saturates at HOLD_MAX exactly when long has fired, which suppresses the short event.
    assign long_evt  = ~sync2 & (hold == HOLD_MAX - 1'b1);
    assign short_evt = rise_evt & (hold != HOLD_MAX);

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode sequencer for the digital clock: turns mode/select button presses and the
// 1 Hz tick into the display/edit state code driven to led_driver.
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int LONG_PRESS_CYC = 50_000_000,
    parameter int IDLE_TIMEOUT_S = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_btn,
    input  logic       sel_btn,
    input  logic       up_btn,
    input  logic       down_btn,
    input  logic       tick_1hz,
    output logic [3:0] state,
    output logic       edit_active,
    output logic       field_adv,
    output logic       edit_exit
);

    localparam int IW = $clog2(IDLE_TIMEOUT_S + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT_S);

    logic mode_short, mode_long, mode_fall, mode_rise;
    logic sel_short, sel_long, sel_fall, sel_rise;
    logic [1:0] ud_sync1, ud_sync2, ud_prev;
    logic fall_any, edge_any, sel_evt, timeout;

    logic [3:0]    state_reg, state_next;
    logic          edit_active_reg;
    logic          field_adv_reg, field_adv_next;
    logic          edit_exit_reg, edit_exit_next;
    logic [IW-1:0] idle_reg;

    btn_press_detect #(.LONG_PRESS_CYC(LONG_PRESS_CYC)) u_mode (
        .clk(clk), .rst_n(rst_n), .btn(mode_btn),
        .short_evt(mode_short), .long_evt(mode_long), .fall_evt(mode_fall), .rise_evt(mode_rise)
    );

    btn_press_detect #(.LONG_PRESS_CYC(LONG_PRESS_CYC)) u_sel (
        .clk(clk), .rst_n(rst_n), .btn(sel_btn),
        .short_evt(sel_short), .long_evt(sel_long), .fall_evt(sel_fall), .rise_evt(sel_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ud_sync1 <= 2'b11;
            ud_sync2 <= 2'b11;
            ud_prev  <= 2'b11;
        end else begin
            ud_sync1 <= {down_btn, up_btn};
            ud_sync2 <= ud_sync1;
            ud_prev  <= ud_sync2;
        end
    end

    assign fall_any = mode_fall | sel_fall | (|(ud_prev & ~ud_sync2));
    assign edge_any = fall_any | mode_rise | sel_rise | (|(~ud_prev & ud_sync2));
    assign sel_evt  = sel_short | sel_long;
    // Any button edge in the same cycle cancels the tick that would have expired the edit.
    assign timeout  = tick_1hz & ~edge_any & (idle_reg == IDLE_MAX - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= TIME_DISP;
            edit_active_reg <= 1'b0;
            field_adv_reg   <= 1'b0;
            edit_exit_reg   <= 1'b0;
            idle_reg        <= '0;
        end else begin
            state_reg       <= state_next;
            edit_active_reg <= is_edit(state_next);
            field_adv_reg   <= field_adv_next;
            edit_exit_reg   <= edit_exit_next;
            if (state_next != state_reg || fall_any || (tick_1hz && edge_any))
                idle_reg <= '0;
            else if (tick_1hz && is_edit(state_reg) && idle_reg != IDLE_MAX)
                idle_reg <= idle_reg + 1'b1;
        end
    end

    always_comb begin
        state_next     = state_reg;
        field_adv_next = 1'b0;
        edit_exit_next = 1'b0;
        case (state_reg)
            TIME_DISP:  if (mode_short) state_next = DATE_DISP;
                        else if (mode_long) state_next = TIME_EDIT_SECOND;
            DATE_DISP:  if (mode_short) state_next = ALARM_DISP;
                        else if (mode_long) state_next = TIME_EDIT_SECOND;
            ALARM_DISP: if (mode_short) state_next = TIMER_DISP;
                        else if (mode_long) state_next = ALARM_EDIT_SECOND;
            TIMER_DISP: if (mode_short) state_next = TIME_DISP;
                        else if (mode_long) state_next = TIMER_EDIT_SECOND;
            TIME_EDIT_SECOND, TIME_EDIT_MINUTE, TIME_EDIT_HOUR,
            TIME_EDIT_DAY, TIME_EDIT_MONTH, TIME_EDIT_YEAR,
            ALARM_EDIT_SECOND, ALARM_EDIT_MINUTE, ALARM_EDIT_HOUR,
            TIMER_EDIT_SECOND, TIMER_EDIT_MINUTE, TIMER_EDIT_HOUR: begin
                // A short mode press is swallowed here and still takes priority over sel.
                if (mode_long) begin
                    state_next     = group_disp(state_reg);
                    edit_exit_next = 1'b1;
                end else if (!mode_short && sel_evt) begin
                    state_next     = next_field(state_reg);
                    field_adv_next = 1'b1;
                end else if (!mode_short && timeout) begin
                    state_next     = group_disp(state_reg);
                    edit_exit_next = 1'b1;
                end
            end
            default: state_next = TIME_DISP;
        endcase
    end

    always_comb begin
        state       = state_reg;
        edit_active = edit_active_reg;
        field_adv   = field_adv_reg;
        edit_exit   = edit_exit_reg;
    end

endmodule
